// File: rtl/rv32_ooo_pkg.sv
// rtl/rv32_ooo_pkg.sv - shared types and constants for the rv32 OoO front end
package rv32_ooo_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch queue, 2-entry push, 0/1/2-entry pop, flush
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all entries (overrides push and pop)
//   push              write push_entry0/push_entry1 at wr_ptr, wr_ptr+1
//   pop               number of head entries consumed this cycle (0..2)
//   head0, head1      entries at rd_ptr and rd_ptr+1
//   count             number of valid entries
module fetch_queue
    import rv32_ooo_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry0,
    input  fetch_entry_t push_entry1,
    input  logic [1:0]   pop,
    output fetch_entry_t head0,
    output fetch_entry_t head1,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Storage carries no reset: entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr]          <= push_entry0;
            mem[wr_ptr + PW'(1)] <= push_entry1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(2);
            end
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (push ? CW'(2) : CW'(0)) - CW'(pop);
            assert (count <= CW'(DEPTH));
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - dual-issue fetch stage: PC, imem requests, fetch queue to decode
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_addr1/imem_addr2        pc and pc+4, driven every cycle
//   imem_instr1/imem_instr2      imem data, one cycle after the address
//   redirect_valid/redirect_pc   flush front end and restart at redirect_pc
//   dec_ready                    decode takes every slot marked in dec_valid
//   dec_valid                    {slot1, slot0}; 2'b10 never occurs
//   dec_instr0/1, dec_pc0/1      oldest and next-oldest queued instructions
module fetch_unit
    import rv32_ooo_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr1,
    output logic [31:0] imem_addr2,
    input  logic [31:0] imem_instr1,
    input  logic [31:0] imem_instr2,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic [1:0]  dec_valid,
    output logic [31:0] dec_instr0,
    output logic [31:0] dec_instr1,
    output logic [31:0] dec_pc0,
    output logic [31:0] dec_pc1
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [31:0]     credit;
    logic            issue;
    logic            push;
    logic [1:0]      pop;
    fetch_entry_t    push_entry0;
    fetch_entry_t    push_entry1;
    fetch_entry_t    head0;
    fetch_entry_t    head1;

    assign imem_addr1 = pc;
    assign imem_addr2 = pc + 32'(INSTR_BYTES);

    // Reserve room for the pair already in flight plus the pair about to be
    // requested. Pops this cycle are not credited, costing at most one bubble.
    assign credit = 32'(count) + (inflight ? 32'd2 : 32'd0) + 32'd2;
    assign issue  = !redirect_valid && (credit <= 32'(FQ_DEPTH));

    // A response landing in a redirect cycle belongs to the wrong path.
    assign push = inflight && !redirect_valid;

    assign dec_valid = {count >= CW'(2), count >= CW'(1)};
    assign pop       = dec_ready ? ({1'b0, dec_valid[1]} + {1'b0, dec_valid[0]}) : 2'b00;

    assign push_entry0 = '{pc: req_pc, instr: imem_instr1};
    assign push_entry1 = '{pc: req_pc + 32'(INSTR_BYTES), instr: imem_instr2};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + 32'(2 * INSTR_BYTES);
            req_pc   <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .push        (push),
        .push_entry0 (push_entry0),
        .push_entry1 (push_entry1),
        .pop         (pop),
        .head0       (head0),
        .head1       (head1),
        .count       (count)
    );

    assign dec_instr0 = head0.instr;
    assign dec_instr1 = head1.instr;
    assign dec_pc0    = head0.pc;
    assign dec_pc1    = head1.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr1;
    logic [31:0] imem_addr2;
    logic [31:0] imem_instr1;
    logic [31:0] imem_instr2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic [1:0]  dec_valid;
    logic [31:0] dec_instr0;
    logic [31:0] dec_instr1;
    logic [31:0] dec_pc0;
    logic [31:0] dec_pc1;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch PC, one outstanding pair, and the ordered list of
    // PCs waiting for decode. Instructions follow from the PC via the imem rule.
    logic [31:0] m_pc;
    logic [31:0] m_req;
    bit          m_pend;
    logic [31:0] mq[$];

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr1     (imem_addr1),
        .imem_addr2     (imem_addr2),
        .imem_instr1    (imem_instr1),
        .imem_instr2    (imem_instr2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .dec_valid      (dec_valid),
        .dec_instr0     (dec_instr0),
        .dec_instr1     (dec_instr1),
        .dec_pc0        (dec_pc0),
        .dec_pc1        (dec_pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    always @(posedge clk) begin
        imem_instr1 <= instr_of(imem_addr1);
        imem_instr2 <= instr_of(imem_addr2);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ev;
        ev = {mq.size() >= 2, mq.size() >= 1};
        check("dec_valid", 32'(dec_valid), 32'(ev));
        check("imem_addr1", imem_addr1, m_pc);
        check("imem_addr2", imem_addr2, m_pc + 32'd4);
        if (ev[0]) begin
            check("dec_pc0", dec_pc0, mq[0]);
            check("dec_instr0", dec_instr0, instr_of(mq[0]));
        end
        if (ev[1]) begin
            check("dec_pc1", dec_pc1, mq[1]);
            check("dec_instr1", dec_instr1, instr_of(mq[1]));
        end
    endtask

    task automatic model_update(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        int  n;
        bit  iss;
        if (r) begin
            m_pc   = RESET_PC;
            m_pend = 1'b0;
            mq.delete();
        end else if (rv) begin
            m_pc   = rpc;
            m_pend = 1'b0;
            mq.delete();
        end else begin
            iss = (mq.size() + (m_pend ? 2 : 0) + 2) <= FQ_DEPTH;
            n   = rdy ? ((mq.size() > 2) ? 2 : mq.size()) : 0;
            repeat (n) void'(mq.pop_front());
            if (m_pend) begin
                mq.push_back(m_req);
                mq.push_back(m_req + 32'd4);
            end
            m_pend = iss;
            if (iss) begin
                m_req = m_pc;
                m_pc  = m_pc + 32'd8;
            end
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        model_update(r, rv, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int thresh;
        bit r;
        bit rv;
        bit rdy;
        logic [31:0] rpc;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        m_pc = RESET_PC; m_req = '0; m_pend = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0);
        check("reset_valid", 32'(dec_valid), 32'd0);
        check("reset_addr1", imem_addr1, RESET_PC);

        // Reset release, first pairs reach decode two cycles after issue.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t1_valid", 32'(dec_valid), 32'd3);
        check("t1_pc0", dec_pc0, 32'h0);
        check("t1_pc1", dec_pc1, 32'h4);
        check("t1_instr0", dec_instr0, 32'h1000_0000);
        check("t1_instr1", dec_instr1, 32'h1000_0001);
        step(0, 0, 0, 1);
        check("t1_pc0_next", dec_pc0, 32'h8);
        check("t1_pc1_next", dec_pc1, 32'hC);

        // Backpressure fills the queue, fetch freezes, drain is in order.
        step(1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        check("t2_addr1_frozen", imem_addr1, 32'h20);
        check("t2_valid_full", 32'(dec_valid), 32'd3);
        for (int k = 0; k < 6; k++) begin
            check("t2_drain_pc0", dec_pc0, 32'(k * 8));
            step(0, 0, 0, 1);
        end

        // Redirect while a response is pending.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h40, 0);
        check("t4_valid", 32'(dec_valid), 32'd0);
        check("t4_addr1", imem_addr1, 32'h40);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t4_pc0", dec_pc0, 32'h40);

        // Reset with six entries queued and a pair in flight.
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        check("t5_valid_before", 32'(dec_valid), 32'd3);
        step(1, 0, 0, 0);
        check("t5_valid", 32'(dec_valid), 32'd0);
        check("t5_addr1", imem_addr1, RESET_PC);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t5_pc0", dec_pc0, RESET_PC);

        // Redirect with dec_ready on a full queue.
        step(1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        step(0, 1, 32'h100, 1);
        check("t6_valid", 32'(dec_valid), 32'd0);
        check("t6_addr1", imem_addr1, 32'h100);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t6_pc0", dec_pc0, 32'h100);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFF8, 1);
        check("wrap_addr2", imem_addr2, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        check("wrap_addr1", imem_addr1, 32'h0);

        // Randomised traffic against the model.
        thresh = 70;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) thresh = $urandom_range(10, 100);
            r   = ($urandom_range(0, 299) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                              : ($urandom & 32'hFFFF_FFFC);
            rdy = ($urandom_range(0, 99) < thresh);
            step(r, rv, rpc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
